lcd_buffer_sched: RTL and testbench

- Owns the 32x8 character buffer read by the LCD controller.
- Address map: 0-15 = top line, 16-31 = bottom line.
- Shares the single buffer write port between three requesters, in this priority order:
  - a full-screen clear engine;
  - a 16-character message copy engine, which reads text from an external synchronous message ROM;
  - single-character writes from the safe/timer logic, used for digits and cursor marks.
- Gives the LCD controller a registered read port.

---
 rtl/lcd_buffer_sched.sv | 94 +++++++++
 tb/tb_lcd_buffer_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lcd_buffer_sched.sv
// lcd_buffer_sched: 32x8 LCD character buffer with clear/copy engines and single-char writes sharing one write port
// clk, rst_n       : clock, synchronous active-low reset
// clr_req          : fill all cells with BLANK_CHAR (held until accepted)
// msg_req, msg_id, msg_line : copy 16-char ROM message into top (0) or bottom (1) line
// busy, done       : engine active, one-cycle completion pulse
// rom_addr, rom_data : synchronous message ROM port (data one cycle after address)
// chr_req, chr_pos, chr_data, chr_ready : single-character write, lowest priority
// rd_addr, rd_data : registered read port for the LCD controller
module lcd_buffer_sched #(
  parameter int MSG_ID_W = 4,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  input  logic                msg_req,
  input  logic [MSG_ID_W-1:0] msg_id,
  input  logic                msg_line,
  output logic                busy,
  output logic                done,
  output logic [MSG_ID_W+3:0] rom_addr,
  input  logic [7:0]          rom_data,
  input  logic                chr_req,
  input  logic [4:0]          chr_pos,
  input  logic [7:0]          chr_data,
  output logic                chr_ready,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_data
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0] state;
  logic [4:0] idx;
  logic [MSG_ID_W-1:0] id;
  logic line;
  logic [7:0] buffer [32];
  logic we;
  logic [4:0] wa;
  logic [7:0] wd;
  logic eng_wr;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign eng_wr = state == S_CLEAR || state == S_WRITE;
  assign chr_ready = !eng_wr;
  always_comb begin
    we = eng_wr || chr_req;
    wa = state == S_CLEAR ? idx : state == S_WRITE ? {line, idx[3:0]} : chr_pos;
    wd = state == S_CLEAR ? BLANK_CHAR : state == S_WRITE ? rom_data : chr_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      id       <= '0;
      line     <= 1'b0;
      rom_addr <= '0;
      rd_data  <= BLANK_CHAR;
      buffer   <= '{default: BLANK_CHAR};
    end else begin
      rd_data <= buffer[rd_addr];
      if (we) buffer[wa] <= wd;
      case (state)
        S_IDLE:
          if (clr_req) begin
            state <= S_CLEAR;
            idx   <= '0;
          end else if (msg_req) begin
            state    <= S_FETCH;
            idx      <= '0;
            id       <= msg_id;
            line     <= msg_line;
            rom_addr <= {msg_id, 4'd0};
          end
        S_CLEAR:
          if (idx == 5'd31) state <= S_DONE;
          else idx <= idx + 5'd1;
        S_FETCH: state <= S_WRITE;
        S_WRITE:
          if (idx == 5'd15) state <= S_DONE;
          else begin
            state    <= S_FETCH;
            idx      <= idx + 5'd1;
            // address the next char now so ROM data lands in the following S_WRITE
            rom_addr <= {id, idx[3:0] + 4'd1};
          end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_buffer_sched.sv
// tb_lcd_buffer_sched: directed self-checking bench for lcd_buffer_sched
module tb_lcd_buffer_sched;
  logic clk = 0, rst_n = 0, clr_req = 0, msg_req = 0, msg_line = 0;
  logic [3:0] msg_id = 0;
  logic busy, done, chr_ready;
  logic [7:0] rom_addr, rom_data, rd_data;
  logic chr_req = 0;
  logic [4:0] chr_pos = 0, rd_addr = 0;
  logic [7:0] chr_data = 0;
  int total = 0, bad = 0;
  int busy_n, done_n, done_at, d1, d2, rom_err, ready_err, acc_n, acc_at, macc, cacc;
  logic acc, m, c;
  lcd_buffer_sched dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .msg_req(msg_req), .msg_id(msg_id),
    .msg_line(msg_line), .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .chr_req(chr_req), .chr_pos(chr_pos), .chr_data(chr_data), .chr_ready(chr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_data <= 8'h41 + {4'h0, rom_addr[3:0]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_chk(input int a, input logic [7:0] exp);
    rd_addr = 5'(a);
    tick();
    chk($sformatf("cell%0d", a), 32'(rd_data), 32'(exp));
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rd_data", rd_data, 8'h20);
    chk("rst_chr_ready", chr_ready, 1);
    rst_n = 1;
    for (int a = 0; a < 32; a++) rd_chk(a, 8'h20);
    // copy message 3 into bottom line with one interleaved single write
    msg_id = 3; msg_line = 1; msg_req = 1;
    tick();
    msg_req = 0;
    chk("copy_rom_addr0", rom_addr, 8'h30);
    busy_n = 0; done_n = 0; done_at = 0; rom_err = 0; ready_err = 0; acc_n = 0; acc_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = k; end
      if (chr_ready !== !(k <= 32 && k % 2 == 0)) ready_err++;
      if (k <= 32 && k % 2 == 1 && rom_addr !== 8'(8'h30 + (k - 1) / 2)) rom_err++;
      if (k == 2) begin chr_pos = 5; chr_data = 8'h37; chr_req = 1; end
      acc = chr_req && chr_ready;
      if (acc) begin acc_n++; acc_at = k; end
      tick();
      if (acc) chr_req = 0;
    end
    chk("copy_busy_cycles", busy_n, 33);
    chk("copy_done_count", done_n, 1);
    chk("copy_done_cycle", done_at, 33);
    chk("copy_rom_addr_seq", rom_err, 0);
    chk("copy_chr_ready", ready_err, 0);
    chk("copy_chr_writes", acc_n, 1);
    chk("copy_chr_cycle", acc_at, 3);
    for (int a = 0; a < 32; a++)
      rd_chk(a, a == 5 ? 8'h37 : a < 16 ? 8'h20 : 8'(8'h41 + a - 16));
    // clear and copy requested together; single write stalls through the clear
    msg_id = 3; msg_line = 0; clr_req = 1; msg_req = 1;
    tick();
    clr_req = 0; chr_pos = 20; chr_data = 8'h55; chr_req = 1;
    d1 = 0; d2 = 0; macc = 0; cacc = 0; ready_err = 0;
    for (int k = 1; k <= 70; k++) begin
      if (k <= 32 && chr_ready) ready_err++;
      if (done) begin if (d1 == 0) d1 = k; else d2 = k; end
      if (k == 34) chk("busy_after_clear", busy, 0);
      m = msg_req && !busy;
      if (m) macc = k;
      c = chr_req && chr_ready;
      if (c) cacc = k;
      tick();
      if (m) msg_req = 0;
      if (c) chr_req = 0;
    end
    chk("clr_chr_ready_low", ready_err, 0);
    chk("clr_done_cycle", d1, 33);
    chk("clr_msg_accept", macc, 34);
    chk("clr_chr_accept", cacc, 33);
    chk("clr_copy_done", d2, 67);
    for (int a = 0; a < 32; a++)
      rd_chk(a, a < 16 ? 8'(8'h41 + a) : a == 20 ? 8'h55 : 8'h20);
    // clear raised during a copy waits for idle
    msg_id = 5; msg_line = 0; msg_req = 1;
    tick();
    msg_req = 0;
    chk("busy_copy_rom_addr0", rom_addr, 8'h50);
    d1 = 0; d2 = 0; cacc = 0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 5) clr_req = 1;
      if (done) begin if (d1 == 0) d1 = k; else d2 = k; end
      m = clr_req && !busy;
      if (m) cacc = k;
      tick();
      if (m) clr_req = 0;
    end
    chk("busy_copy_done", d1, 33);
    chk("busy_clr_accept", cacc, 34);
    chk("busy_clr_done", d2, 67);
    for (int a = 0; a < 32; a++) rd_chk(a, 8'h20);
    // reset in the middle of a copy
    msg_id = 2; msg_line = 1; msg_req = 1; rd_addr = 20;
    tick();
    msg_req = 0;
    for (int k = 1; k <= 12; k++) tick();
    chk("mid_busy", busy, 1);
    chk("mid_cell20", rd_data, 8'h45);
    rst_n = 0;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_rd_data", rd_data, 8'h20);
    rst_n = 1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_n++;
      tick();
    end
    chk("mid_rst_no_done", done_n, 0);
    for (int a = 0; a < 32; a++) rd_chk(a, 8'h20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
